// File: rtl/subtractor_4bits_2steps.sv
// Two-stage pipelined 8-bit subtractor with borrow in/out: the low nibble is resolved in
// stage 1, the high nibble plus the carried borrow in stage 2, with valid/ready on both sides.
module subtractor_4bits_2steps (
    input  logic       clk,
    input  logic       srst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] din_a,
    input  logic [7:0] din_b,
    input  logic       bin,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] diff,
    output logic       bout
);

    // {borrow, difference} of a - b - bi on one nibble; bit 4 wraps to 1 whenever the result is negative
    function automatic logic [4:0] sub_nibble(input logic [3:0] a,
                                              input logic [3:0] b,
                                              input logic       bi);
        logic [4:0] t;
        t = {1'b0, a} - {1'b0, b} - {4'b0000, bi};
        return t;
    endfunction

    logic       accept;
    logic       s2_adv;
    logic [4:0] lo_res_p0;
    logic [4:0] hi_res_p1;

    logic       vld_p1;
    logic [3:0] lo_p1;
    logic       brw_p1;
    logic [3:0] a_hi_p1;
    logic [3:0] b_hi_p1;

    logic       vld_p2;
    logic [7:0] diff_p2;
    logic       bout_p2;

    // Bubble-collapsing flow control: stage 1 always follows stage 2's ability to advance
    assign s2_adv   = !vld_p2 || out_ready;
    assign in_ready = !vld_p1 || s2_adv;
    assign accept   = in_valid && in_ready;

    // ---- stage 0 -> 1: low nibble ----
    assign lo_res_p0 = sub_nibble(din_a[3:0], din_b[3:0], bin);

    always_ff @(posedge clk) begin
        if (srst) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
        end else if (s2_adv) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            lo_p1   <= 4'h0;
            brw_p1  <= 1'b0;
            a_hi_p1 <= 4'h0;
            b_hi_p1 <= 4'h0;
        end else if (accept) begin
            lo_p1   <= lo_res_p0[3:0];
            brw_p1  <= lo_res_p0[4];
            a_hi_p1 <= din_a[7:4];
            b_hi_p1 <= din_b[7:4];
        end
    end

    // ---- stage 1 -> 2: high nibble with the low-nibble borrow ----
    assign hi_res_p1 = sub_nibble(a_hi_p1, b_hi_p1, brw_p1);

    always_ff @(posedge clk) begin
        if (srst) begin
            vld_p2 <= 1'b0;
        end else if (s2_adv) begin
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            diff_p2 <= 8'h00;
            bout_p2 <= 1'b0;
        end else if (s2_adv && vld_p1) begin
            diff_p2 <= {hi_res_p1[3:0], lo_p1};
            bout_p2 <= hi_res_p1[4];
        end
    end

    assign out_valid = vld_p2;
    assign diff      = diff_p2;
    assign bout      = bout_p2;

endmodule
